// File: rtl/memory_issue_queue_if.sv
// ============================================================================
//  Module      : memory_issue_queue_if
//  Description : Dispatch, CDB, ROB-head and issue-port bundle for the memory
//                issue queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_issue_queue_if #(
    parameter int PR_W = 6
);
    logic            flush;
    logic            disp_valid;
    logic            disp_ready;
    logic [3:0]      disp_opcode;
    logic [4:0]      disp_ROB_entry;
    logic [15:0]     disp_base_val;
    logic [3:0]      disp_imm;
    logic [PR_W-1:0] disp_off_preg;
    logic            disp_off_rdy;
    logic [7:0]      disp_off_val;
    logic [PR_W-1:0] disp_dat_preg;
    logic            disp_dat_rdy;
    logic [7:0]      disp_dat_val;
    logic [PR_W-1:0] disp_dest_reg;
    logic [7:0]      disp_dest_arch;
    logic            cdb_valid;
    logic [PR_W-1:0] cdb_preg;
    logic [7:0]      cdb_data;
    logic [4:0]      rob_head;
    logic [3:0]      opcode;
    logic [4:0]      ROB_entry;
    logic [15:0]     base_val;
    logic [7:0]      offset;
    logic [PR_W-1:0] dest_reg;
    logic [7:0]      data;
    logic [3:0]      imm;
    logic [7:0]      dest_arch_regs;
    logic            output_valid;
    logic            output_ready;

    // Environment side: dispatch stage, CDB, ROB and memory pipeline.
    modport master (
        output flush, disp_valid, disp_opcode, disp_ROB_entry, disp_base_val,
               disp_imm, disp_off_preg, disp_off_rdy, disp_off_val,
               disp_dat_preg, disp_dat_rdy, disp_dat_val, disp_dest_reg,
               disp_dest_arch, cdb_valid, cdb_preg, cdb_data, rob_head,
               output_ready,
        input  disp_ready, opcode, ROB_entry, base_val, offset, dest_reg,
               data, imm, dest_arch_regs, output_valid
    );

    modport slave (
        input  flush, disp_valid, disp_opcode, disp_ROB_entry, disp_base_val,
               disp_imm, disp_off_preg, disp_off_rdy, disp_off_val,
               disp_dat_preg, disp_dat_rdy, disp_dat_val, disp_dest_reg,
               disp_dest_arch, cdb_valid, cdb_preg, cdb_data, rob_head,
               output_ready,
        output disp_ready, opcode, ROB_entry, base_val, offset, dest_reg,
               data, imm, dest_arch_regs, output_valid
    );
endinterface

`default_nettype wire

// File: rtl/memory_issue_queue.sv
// ============================================================================
//  Module      : memory_issue_queue
//  Description : In-order load/store issue queue with CDB operand wakeup;
//                stores issue only when they are the ROB head.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int PR_W  = 6
) (
    input  wire logic             clk,
    input  wire logic             rst,
    memory_issue_queue_if.slave   bus
);
    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] r_vld;
    logic [3:0]       r_opcode   [DEPTH];
    logic [4:0]       r_rob      [DEPTH];
    logic [15:0]      r_base     [DEPTH];
    logic [3:0]       r_imm      [DEPTH];
    logic [PR_W-1:0]  r_off_preg [DEPTH];
    logic             r_off_rdy  [DEPTH];
    logic [7:0]       r_off_val  [DEPTH];
    logic [PR_W-1:0]  r_dat_preg [DEPTH];
    logic             r_dat_rdy  [DEPTH];
    logic [7:0]       r_dat_val  [DEPTH];
    logic [PR_W-1:0]  r_dest     [DEPTH];
    logic [7:0]       r_arch     [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_out_valid;
    logic [3:0]       r_out_opcode;
    logic [4:0]       r_out_rob;
    logic [15:0]      r_out_base;
    logic [7:0]       r_out_off;
    logic [PR_W-1:0]  r_out_dest;
    logic [7:0]       r_out_dat;
    logic [3:0]       r_out_imm;
    logic [7:0]       r_out_arch;

    logic w_push;
    logic w_pop;
    logic w_head_issuable;
    logic w_disp_off_hit;
    logic w_disp_dat_hit;

    assign bus.disp_ready = (r_count != c_depth);
    assign w_push         = bus.disp_valid & bus.disp_ready;

    // Stores must wait for the ROB head so they never execute speculatively.
    assign w_head_issuable = (r_count != '0) & r_off_rdy[r_head] & r_dat_rdy[r_head]
                           & (~r_opcode[r_head][0] | (r_rob[r_head] == bus.rob_head));
    assign w_pop = (~r_out_valid | bus.output_ready) & w_head_issuable;

    assign w_disp_off_hit = bus.cdb_valid & ~bus.disp_off_rdy & (bus.disp_off_preg == bus.cdb_preg);
    assign w_disp_dat_hit = bus.cdb_valid & ~bus.disp_dat_rdy & (bus.disp_dat_preg == bus.cdb_preg);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_vld       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && !r_off_rdy[i] && bus.cdb_valid && r_off_preg[i] == bus.cdb_preg) begin
                    r_off_rdy[i] <= 1'b1;
                    r_off_val[i] <= bus.cdb_data;
                end
                if (r_vld[i] && !r_dat_rdy[i] && bus.cdb_valid && r_dat_preg[i] == bus.cdb_preg) begin
                    r_dat_rdy[i] <= 1'b1;
                    r_dat_val[i] <= bus.cdb_data;
                end
            end

            // Tail slot is never valid while pushing, so it cannot collide with wakeup or pop.
            if (w_push) begin
                r_vld[r_tail]      <= 1'b1;
                r_opcode[r_tail]   <= bus.disp_opcode;
                r_rob[r_tail]      <= bus.disp_ROB_entry;
                r_base[r_tail]     <= bus.disp_base_val;
                r_imm[r_tail]      <= bus.disp_imm;
                r_off_preg[r_tail] <= bus.disp_off_preg;
                r_off_rdy[r_tail]  <= bus.disp_off_rdy | w_disp_off_hit;
                r_off_val[r_tail]  <= w_disp_off_hit ? bus.cdb_data : bus.disp_off_val;
                r_dat_preg[r_tail] <= bus.disp_dat_preg;
                r_dat_rdy[r_tail]  <= bus.disp_dat_rdy | w_disp_dat_hit;
                r_dat_val[r_tail]  <= w_disp_dat_hit ? bus.cdb_data : bus.disp_dat_val;
                r_dest[r_tail]     <= bus.disp_dest_reg;
                r_arch[r_tail]     <= bus.disp_dest_arch;
                r_tail             <= r_tail + 1'b1;
            end

            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
                r_out_valid   <= 1'b1;
                r_out_opcode  <= r_opcode[r_head];
                r_out_rob     <= r_rob[r_head];
                r_out_base    <= r_base[r_head];
                r_out_off     <= r_off_val[r_head];
                r_out_dest    <= r_dest[r_head];
                r_out_dat     <= r_dat_val[r_head];
                r_out_imm     <= r_imm[r_head];
                r_out_arch    <= r_arch[r_head];
            end else if (bus.output_ready) begin
                r_out_valid <= 1'b0;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.output_valid   = r_out_valid;
    assign bus.opcode         = r_out_opcode;
    assign bus.ROB_entry      = r_out_rob;
    assign bus.base_val       = r_out_base;
    assign bus.offset         = r_out_off;
    assign bus.dest_reg       = r_out_dest;
    assign bus.data           = r_out_dat;
    assign bus.imm            = r_out_imm;
    assign bus.dest_arch_regs = r_out_arch;

endmodule

`default_nettype wire
